efb_wb_arbiter: RTL
===================

EFB_WB_ARBITER -- requirements
Module: efb_wb_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the number of BUSY cycles without wb_ack_i before abort (ARB_TIMEOUT_EN only); legal range 1..255.
REQ-002 clk_i  input  1  sole clock; all state SHALL change on its rising edge, except on reset.
REQ-003 rst_n_i  input  1  reset; asynchronous, active-low.
REQ-004 m_cyc_i  input  3  per-requester cycle request; bit k = requester k.
REQ-005 m_we_i  input  3  per-requester write-enable.
REQ-006 m_adr_i  input  24  requester k register address in bits [8k+7:8k].
REQ-007 m_dat_i  input  24  requester k write data in bits [8k+7:8k].
REQ-008 m_lock_i  input  3  requester k asks to keep the grant after its current cycle.
REQ-009 m_ack_o  output  3  one-cycle completion pulse to the granted requester.
REQ-010 m_err_o  output  3  one-cycle abort pulse to the granted requester.
REQ-011 m_dat_o  output  8  read data, broadcast to all requesters.
REQ-012 wb_cyc_o, wb_stb_o  output  1 each  EFB cycle/strobe; always equal.
REQ-013 wb_we_o  output  1; wb_adr_o  output  8; wb_dat_o  output  8  EFB write-enable, address and write data.
REQ-014 wb_dat_i  input  8; wb_ack_i  input  1  EFB read data and acknowledge.
REQ-015 grant_o  output  3  one-hot current owner; 0 when no owner.

Function
REQ-016 States SHALL be IDLE, BUSY, DONE and LOCKED.
REQ-017 Priority: IDLE SHALL grant the first requester with m_cyc_i set, scanning from rr_ptr upward modulo 3.
REQ-018 Grant timing: a grant chosen at edge t SHALL latch that requester's we, adr and dat into wb_we_o, wb_adr_o and wb_dat_o, set wb_cyc_o and grant_o, and enter BUSY; wb_cyc_o is high from t+1.
REQ-019 BUSY: the slave-side outputs SHALL hold constant until wb_ack_i is sampled high.
REQ-020 Ack handling: on wb_ack_i at edge a, wb_cyc_o SHALL clear and m_dat_o SHALL load wb_dat_i; m_ack_o[g] SHALL be high for exactly the cycle after a; state SHALL go to DONE.
REQ-021 m_dat_o SHALL hold its value until the next acknowledged cycle, for reads and writes alike.
REQ-022 DONE lasts one cycle and SHALL ignore all m_cyc_i, so the requester can drop cyc; m_lock_i[g] sampled in DONE selects LOCKED if 1, else IDLE.
REQ-023 On the transition to IDLE, rr_ptr SHALL become (g+1) mod 3 and grant_o SHALL become 0.
REQ-024 LOCKED: grant_o stays g; only m_cyc_i[g] starts a cycle, with REQ-018 timing; other requests SHALL wait.
REQ-025 LOCKED with m_lock_i[g]=0 and m_cyc_i[g]=0 SHALL go to IDLE, per REQ-023.
REQ-026 m_lock_i of a non-owner SHALL be ignored.
REQ-027 Simultaneous requests SHALL resolve by REQ-017 only; a request is never lost while its m_cyc_i stays high.
REQ-028 m_ack_o and m_err_o SHALL never both be high, and never on a non-granted bit.

Reset
REQ-029 Reset asserted SHALL immediately force IDLE, clear all outputs and m_dat_o to 0, and set rr_ptr=0; the timeout counter is cleared.
REQ-030 Reset during BUSY SHALL drop wb_cyc_o with no ack or err generated.
REQ-031 Reset release SHALL be sampled synchronously; the first grant is possible at the first edge after release.

Configuration
REQ-032 With macro ARB_TIMEOUT_EN defined, an 8-bit counter SHALL clear on BUSY entry and increment each BUSY cycle without ack.
REQ-033 With ARB_TIMEOUT_EN defined, when the counter equals TIMEOUT_CYCLES: wb_cyc_o clears, m_err_o[g] pulses once, m_dat_o is unchanged, lock is ignored and the state goes DONE then IDLE.
REQ-034 With ARB_TIMEOUT_EN defined, an ack on the expiry edge SHALL win: normal ack, no error.
REQ-035 Without ARB_TIMEOUT_EN, no counter SHALL exist, m_err_o SHALL be constant 0, and BUSY SHALL wait indefinitely.

Verification
REQ-036 Single read: req1 read adr 0x08, slave acks 3 cycles later with 0x5A -> wb_cyc_o high 1 cycle after request, m_ack_o=3'b010 for one cycle, m_dat_o=0x5A.
REQ-037 Contention: all three m_cyc_i set at once, no locks, after reset -> grants in order 0, 1, 2, then next round starts at 0.
REQ-038 Lock: req2 holds lock across writes 0x90, 0xD0, 0x40 to adr 0x41 while req0 requests -> req0 granted only after req2 drops lock; wb_adr_o and wb_dat_o never show req0 data in between.
REQ-039 Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): no ack -> wb_cyc_o drops after 4 BUSY cycles, m_err_o[g] pulses, m_dat_o unchanged; ack on the 4th cycle -> m_ack_o, no error.
REQ-040 Reset mid-BUSY: rst_n_i low while wb_cyc_o=1 -> wb_cyc_o=0 the same cycle, no ack or err, next grant goes to requester 0.

Source files
------------

// File: rtl/efb_wb_arbiter.sv
// Three-requester round-robin Wishbone arbiter in front of the EFB slave port, with per-owner lock.
// Optional BUSY watchdog is compiled in with `define ARB_TIMEOUT_EN.
module efb_wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [2:0]  m_cyc_i,
  input  logic [2:0]  m_we_i,
  input  logic [23:0] m_adr_i,
  input  logic [23:0] m_dat_i,
  input  logic [2:0]  m_lock_i,
  output logic [2:0]  m_ack_o,
  output logic [2:0]  m_err_o,
  output logic [7:0]  m_dat_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [7:0]  wb_adr_o,
  output logic [7:0]  wb_dat_o,
  input  logic [7:0]  wb_dat_i,
  input  logic        wb_ack_i,
  output logic [2:0]  grant_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, LOCKED} state_t;

  state_t      state_q, state_d;
  logic [2:0]  grant_q, grant_d, ack_q, ack_d;
  logic [1:0]  own_q, own_d, rr_q, rr_d;
  logic        cyc_q, cyc_d, we_q, we_d;
  logic [7:0]  adr_q, adr_d, dat_q, dat_d, mdat_q, mdat_d;
  logic        start, leave;
  logic [1:0]  start_idx;
  logic [2:0]  pick;
`ifdef ARB_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
  logic        abort_q, abort_d;
  logic [2:0]  err_q, err_d;
`endif

  // Returns {found, index} of the first request at or after ptr, wrapping modulo 3.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [2:0]  res;
    int unsigned k;
    res = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      k = (int'(ptr) + i) % 3;
      if (req[k]) res = {1'b1, 2'(k)};
    end
    return res;
  endfunction

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic logic [7:0] sel8(input logic [23:0] v, input logic [1:0] idx);
    case (idx)
      2'd0:    return v[7:0];
      2'd1:    return v[15:8];
      default: return v[23:16];
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    own_d     = own_q;
    rr_d      = rr_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    mdat_d    = mdat_q;
    ack_d     = 3'b000;
    start     = 1'b0;
    leave     = 1'b0;
    start_idx = own_q;
    pick      = rr_pick(m_cyc_i, rr_q);
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    err_d     = 3'b000;
`endif

    case (state_q)
      IDLE: begin
        if (pick[2]) begin
          start     = 1'b1;
          start_idx = pick[1:0];
        end
      end
      BUSY: begin
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          mdat_d  = wb_dat_i;
          ack_d   = grant_q;
          state_d = DONE;
`ifdef ARB_TIMEOUT_EN
          abort_d = 1'b0;
`endif
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q + 8'd1 == 8'(TIMEOUT_CYCLES)) begin
          cyc_d   = 1'b0;
          err_d   = grant_q;
          abort_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      DONE: begin
        // Requests are deliberately ignored here so the owner can drop cyc.
        leave = !m_lock_i[own_q];
`ifdef ARB_TIMEOUT_EN
        if (abort_q) leave = 1'b1;
`endif
        state_d = leave ? IDLE : LOCKED;
      end
      LOCKED: begin
        if (m_cyc_i[own_q]) start = 1'b1;
        else if (!m_lock_i[own_q]) leave = 1'b1;
        if (leave) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (leave) begin
      rr_d    = rr_next(own_q);
      grant_d = 3'b000;
    end

    if (start) begin
      own_d   = start_idx;
      grant_d = 3'b001 << start_idx;
      cyc_d   = 1'b1;
      we_d    = m_we_i[start_idx];
      adr_d   = sel8(m_adr_i, start_idx);
      dat_d   = sel8(m_dat_i, start_idx);
      state_d = BUSY;
`ifdef ARB_TIMEOUT_EN
      cnt_d   = 8'd0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
      own_q   <= 2'd0;
      rr_q    <= 2'd0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 8'd0;
      dat_q   <= 8'd0;
      mdat_q  <= 8'd0;
      ack_q   <= 3'b000;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= 8'd0;
      abort_q <= 1'b0;
      err_q   <= 3'b000;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      own_q   <= own_d;
      rr_q    <= rr_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      mdat_q  <= mdat_d;
      ack_q   <= ack_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      err_q   <= err_d;
`endif
    end
  end

  assign m_ack_o  = ack_q;
  assign m_dat_o  = mdat_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign grant_o  = grant_q;
`ifdef ARB_TIMEOUT_EN
  assign m_err_o  = err_q;
`else
  assign m_err_o  = 3'b000;
`endif

endmodule
